// File: rtl/demux_channel_scheduler.sv
// Buffers {channel, data} requests in a small FIFO and plays each one out on the
// 1:4 demux inputs (a, s1, s0) for DWELL cycles, back-to-back and in arrival order.
module demux_channel_scheduler #(
    parameter int DEPTH = 4,
    parameter int DWELL = 2,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_ch,
    input  logic             in_data,
    output logic             a,
    output logic             s1,
    output logic             s0,
    output logic             strobe,
    output logic             busy,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    // Handshake: a request transfers at a rising edge where in_valid && in_ready;
    // the source holds {in_ch, in_data} stable until that edge.

    typedef enum logic {IDLE, DRIVE} state_t;

    logic [2:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DCNT_W-1:0] dcnt_q;
    state_t            state_q;
    logic              a_q, s1_q, s0_q, strobe_q;
    logic              push, pop;
    logic [2:0]        head;

    assign in_ready = (level_q != LVL_W'(DEPTH));
    assign push     = in_valid && in_ready;
    // Pop decision uses the pre-edge level, so a same-edge push is never bypassed.
    assign pop      = (level_q != '0) && ((state_q == IDLE) || (dcnt_q == '0));
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_ch, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dcnt_q   <= '0;
            state_q  <= IDLE;
            a_q      <= 1'b0;
            s1_q     <= 1'b0;
            s0_q     <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        {s1_q, s0_q, a_q} <= head;
                        strobe_q          <= 1'b1;
                        dcnt_q            <= DCNT_W'(DWELL - 1);
                        state_q           <= DRIVE;
                    end else begin
                        a_q <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (dcnt_q != '0) begin
                        dcnt_q <= dcnt_q - DCNT_W'(1);
                    end else if (pop) begin
                        {s1_q, s0_q, a_q} <= head;
                        strobe_q          <= 1'b1;
                        dcnt_q            <= DCNT_W'(DWELL - 1);
                    end else begin
                        // Selects keep their last value so the demux output settles low.
                        a_q     <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a      = a_q;
    assign s1     = s1_q;
    assign s0     = s0_q;
    assign strobe = strobe_q;
    assign busy   = (state_q == DRIVE);
    assign level  = level_q;

endmodule

// File: tb/tb_demux_channel_scheduler.sv
// Directed bench for demux_channel_scheduler: a queue-based model checked every cycle,
// plus literal expectations for the reset, single-entry, burst, full and reset cases.
module tb_demux_channel_scheduler;

    localparam int DEPTH = 4;
    localparam int DWELL = 2;
    localparam int LVL_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_ch;
    logic             in_data;
    logic             a, s1, s0, strobe, busy;
    logic [LVL_W-1:0] level;

    int tests_run = 0;
    int tests_failed = 0;

    demux_channel_scheduler #(.DEPTH(DEPTH), .DWELL(DWELL), .LVL_W(LVL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_data(in_data), .a(a), .s1(s1), .s0(s0),
        .strobe(strobe), .busy(busy), .level(level)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: FIFO contents, current entry and cycles remaining on it
    logic [2:0] exp_q[$];
    logic       m_a;
    logic [1:0] m_s;
    logic       m_strobe;
    int         m_rem = 0;
    bit         model_ok = 1'b0;
    logic       m_acc;
    logic [2:0] m_acc_d, m_e;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_a = 1'b0; m_s = 2'b00; m_strobe = 1'b0; m_rem = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_acc   = in_valid && (exp_q.size() != DEPTH);
            m_acc_d = {in_ch, in_data};
            if (m_rem <= 1) begin
                if (exp_q.size() != 0) begin
                    m_e = exp_q.pop_front();
                    m_s = m_e[2:1]; m_a = m_e[0]; m_strobe = 1'b1; m_rem = DWELL;
                end else begin
                    m_rem = 0; m_a = 1'b0; m_strobe = 1'b0;
                end
            end else begin
                m_rem = m_rem - 1;
                m_strobe = 1'b0;
            end
            if (m_acc) exp_q.push_back(m_acc_d);
        end
    end

    // per-cycle compare against the model, plus strobe logging
    logic [2:0] strobe_log[$];
    int         strobe_cyc[$];
    int         cyc = 0;
    int         strobe_cnt = 0;
    logic [8:0] act_v, exp_v;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (model_ok) begin
            act_v = {a, s1, s0, strobe, busy, level, in_ready};
            exp_v = {m_a, m_s, m_strobe, (m_rem != 0), LVL_W'(exp_q.size()),
                     (exp_q.size() != DEPTH)};
            tests_run = tests_run + 1;
            if (act_v !== exp_v) begin
                tests_failed = tests_failed + 1;
                $display("FAIL cycle_model t=%0t {a,s1,s0,strobe,busy,level,rdy} got %b want %b",
                         $time, act_v, exp_v);
            end
            if (strobe === 1'b1) begin
                strobe_cnt = strobe_cnt + 1;
                strobe_log.push_back({s1, s0, a});
                strobe_cyc.push_back(cyc);
            end
        end
    end

    // driver tasks
    task automatic chk(input string name, input int act, input int exp);
        tests_run = tests_run + 1;
        if (act != exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic v, input logic [1:0] ch, input logic d);
        in_valid = v; in_ch = ch; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_rem != 0 || exp_q.size() != 0) && n < 100) begin
            drive_cycle(1'b0, 2'd0, 1'b0);
            n++;
        end
        chk("drain_timeout", n < 100, 1);
    endtask

    int  k, n, max_lvl;
    bit  saw_full;
    logic [2:0] seq_d;

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_ch = 2'd3; in_data = 1'b1;

        // T1: reset held 3 cycles with a request present
        repeat (3) begin @(posedge clk); #1; end
        chk("t1_a", a, 0); chk("t1_sel", {s1, s0}, 0); chk("t1_level", level, 0);
        chk("t1_busy", busy, 0); chk("t1_ready", in_ready, 1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        drive_cycle(1'b0, 2'd0, 1'b0);
        chk("t1_after_level", level, 0);
        chk("t1_after_strobe", strobe, 0);

        // T2: single entry ch=2 data=1
        drive_cycle(1'b1, 2'd2, 1'b1);
        drive_cycle(1'b0, 2'd0, 1'b0);
        chk("t2_e1_a", a, 1); chk("t2_e1_sel", {s1, s0}, 2); chk("t2_e1_strobe", strobe, 1);
        drive_cycle(1'b0, 2'd0, 1'b0);
        chk("t2_e2_a", a, 1); chk("t2_e2_strobe", strobe, 0); chk("t2_e2_busy", busy, 1);
        drive_cycle(1'b0, 2'd0, 1'b0);
        chk("t2_e3_a", a, 0); chk("t2_e3_busy", busy, 0); chk("t2_e3_sel", {s1, s0}, 2);

        // T3: burst ch=0..3 data=1,0,1,1
        strobe_log.delete(); strobe_cyc.delete(); strobe_cnt = 0;
        drive_cycle(1'b1, 2'd0, 1'b1);
        drive_cycle(1'b1, 2'd1, 1'b0);
        drive_cycle(1'b1, 2'd2, 1'b1);
        drive_cycle(1'b1, 2'd3, 1'b1);
        drain();
        chk("t3_strobes", strobe_cnt, 4);
        if (strobe_log.size() == 4) begin
            chk("t3_entry0", strobe_log[0], 3'b001);
            chk("t3_entry1", strobe_log[1], 3'b010);
            chk("t3_entry2", strobe_log[2], 3'b101);
            chk("t3_entry3", strobe_log[3], 3'b111);
            for (int i = 1; i < 4; i++)
                chk("t3_spacing", strobe_cyc[i] - strobe_cyc[i-1], 2);
        end

        // T4: continuous pushes until full; garbage offered while not ready is ignored
        k = 0; n = 0; max_lvl = 0; saw_full = 1'b0;
        while (k < 8 && n < 40) begin
            if (in_ready) begin
                seq_d = 3'(k + 3);
                in_valid = 1'b1; in_ch = seq_d[2:1]; in_data = seq_d[0];
                k++;
            end else begin
                saw_full = 1'b1;
                in_valid = 1'b1; in_ch = 2'($urandom_range(0, 3)); in_data = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            n++;
        end
        chk("t4_pushes_done", k, 8);
        chk("t4_max_level", max_lvl, 4);
        chk("t4_saw_not_ready", saw_full, 1);
        drain();

        // T5: hold level at 2 by pushing only on pop edges once 2 deep
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() < 2 || (m_rem <= 1 && exp_q.size() != 0)) begin
                seq_d = 3'($urandom_range(0, 7));
                in_valid = 1'b1; in_ch = seq_d[2:1]; in_data = seq_d[0];
                n++;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        chk("t5_level_steady", level, 2);
        chk("t5_enough_entries", n >= 12, 1);
        drain();

        // T6: reset mid-DRIVE with 3 entries queued
        n = 0;
        while (exp_q.size() < 3 && n < 20) begin
            in_valid = 1'b1; in_ch = 2'(n); in_data = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n++;
        end
        chk("t6_queued", level, 3);
        chk("t6_busy_before", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t6_a", a, 0); chk("t6_sel", {s1, s0}, 0); chk("t6_level", level, 0);
        chk("t6_busy", busy, 0); chk("t6_strobe", strobe, 0);
        strobe_cnt = 0;
        repeat (8) drive_cycle(1'b0, 2'd0, 1'b0);
        chk("t6_no_stale_strobe", strobe_cnt, 0);
        chk("t6_level_after", level, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
